req_sequencer: RTL and testbench

REQ_SEQUENCER -- requirements
Module: req_sequencer

---
 rtl/req_seq_pkg.sv | 14 +
 rtl/req_seq_chan.sv | 109 ++++++++++
 rtl/req_sequencer.sv | 53 +++++
 tb/tb_req_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/req_seq_pkg.sv
// Shared types and constants for the two-channel request sequencer.
package req_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DROP = 2'd3
  } chan_state_e;

  localparam logic [2:0] REQ_ON  = 3'b001;
  localparam logic [2:0] REQ_OFF = 3'b000;

endpackage

// File: rtl/req_seq_chan.sv
// One sequencer channel: job FIFO, request FSM and granted-cycle counter.
module req_chan
  import req_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid_i,
  input  logic [LEN_W-1:0] job_len_i,
  output logic             job_ready_o,
  input  logic [2:0]       gnt_i,
  output logic [2:0]       req_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  chan_state_e      state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [2:0]       req_q;
  logic             done_q;
  logic             empty, full, push, pop, granted;

  // The extra pointer MSB tells a wrapped-full FIFO apart from an empty one.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push    = job_valid_i && !full;
  assign pop     = (state_q == IDLE) && !empty;
  assign granted = |gnt_i;

  assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= job_len_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= REQ_OFF;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking default; a later assignment in the same cycle wins.
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            cnt_q   <= mem_q[rd_ptr_q[AW-1:0]];
            req_q   <= REQ_ON;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (granted) begin
            if (cnt_q == '0) begin
              req_q   <= REQ_OFF;
              done_q  <= 1'b1;
              state_q <= DROP;
            end else begin
              state_q <= XFER;
            end
          end
        end
        XFER: begin
          // Entered with cnt_q >= 1, so the decrement cannot underflow.
          if (granted) begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              req_q   <= REQ_OFF;
              done_q  <= 1'b1;
              state_q <= DROP;
            end
          end
        end
        DROP: begin
          if (!granted) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign job_ready_o = !full;
  assign req_o       = req_q;
  assign done_o      = done_q;
  assign busy_o      = !empty || (state_q != IDLE);

endmodule

// File: rtl/req_sequencer.sv
// Two independent request-sequencer channels sharing clock and reset.
module req_sequencer
  import req_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid_0,
  input  logic [LEN_W-1:0] job_len_0,
  output logic             job_ready_0,
  input  logic [2:0]       gnt_0,
  output logic [2:0]       req_0,
  output logic             done_0,
  input  logic             job_valid_1,
  input  logic [LEN_W-1:0] job_len_1,
  output logic             job_ready_1,
  input  logic [2:0]       gnt_1,
  output logic [2:0]       req_1,
  output logic             done_1,
  output logic             busy
);

  logic busy_0, busy_1;

  req_chan #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_chan_0 (
    .clock       (clock),
    .reset       (reset),
    .job_valid_i (job_valid_0),
    .job_len_i   (job_len_0),
    .job_ready_o (job_ready_0),
    .gnt_i       (gnt_0),
    .req_o       (req_0),
    .done_o      (done_0),
    .busy_o      (busy_0)
  );

  req_chan #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_chan_1 (
    .clock       (clock),
    .reset       (reset),
    .job_valid_i (job_valid_1),
    .job_len_i   (job_len_1),
    .job_ready_o (job_ready_1),
    .gnt_i       (gnt_1),
    .req_o       (req_1),
    .done_o      (done_1),
    .busy_o      (busy_1)
  );

  assign busy = busy_0 | busy_1;

endmodule

// File: tb/tb_req_sequencer.sv
// Scoreboard bench: each accepted job queues its expected granted-cycle count (L+1).
module tb_req_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       job_valid_0 = 1'b0, job_valid_1 = 1'b0;
  logic [3:0] job_len_0 = '0, job_len_1 = '0;
  logic [2:0] gnt_0 = '0, gnt_1 = '0;
  logic       job_ready_0, job_ready_1, done_0, done_1, busy;
  logic [2:0] req_0, req_1;

  bit arb_en0 = 1'b1, arb_en1 = 1'b1;
  int g0 = 0, g1 = 0;
  int q0[$], q1[$];
  bit pd0 = 1'b0, pd1 = 1'b0;
  int total = 0, bad = 0;
  int snap;

  req_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
    .clock(clock), .reset(reset),
    .job_valid_0(job_valid_0), .job_len_0(job_len_0), .job_ready_0(job_ready_0),
    .gnt_0(gnt_0), .req_0(req_0), .done_0(done_0),
    .job_valid_1(job_valid_1), .job_len_1(job_len_1), .job_ready_1(job_ready_1),
    .gnt_1(gnt_1), .req_1(req_1), .done_1(done_1),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: score the cycle about to close, advance, then run the arbiter model.
  task automatic tick();
    if (job_valid_0 && job_ready_0) q0.push_back(int'(job_len_0) + 1);
    if (job_valid_1 && job_ready_1) q1.push_back(int'(job_len_1) + 1);
    if (req_0 != 3'b000 && gnt_0 != 3'b000) g0++;
    if (req_1 != 3'b000 && gnt_1 != 3'b000) g1++;
    @(posedge clock);
    #1;
    if (pd0) check("done0_width", done_0, 1'b0);
    if (pd1) check("done1_width", done_1, 1'b0);
    if (done_0) begin
      check("req0_at_done", req_0, 3'b000);
      if (q0.size() == 0) check("done0_unexpected", done_0, 1'b0);
      else check("gnt_cycles0", g0, q0.pop_front());
      g0 = 0;
    end
    if (done_1) begin
      check("req1_at_done", req_1, 3'b000);
      if (q1.size() == 0) check("done1_unexpected", done_1, 1'b0);
      else check("gnt_cycles1", g1, q1.pop_front());
      g1 = 0;
    end
    pd0 = done_0;
    pd1 = done_1;
    gnt_0 = (arb_en0 && req_0 != 3'b000) ? 3'($urandom_range(1, 7)) : 3'b000;
    gnt_1 = (arb_en1 && req_1 != 3'b000) ? 3'($urandom_range(1, 7)) : 3'b000;
  endtask

  task automatic offer(input int ch, input logic [3:0] len);
    if (ch == 0) begin job_valid_0 = 1'b1; job_len_0 = len; end
    else         begin job_valid_1 = 1'b1; job_len_1 = len; end
    tick();
    job_valid_0 = 1'b0;
    job_valid_1 = 1'b0;
  endtask

  task automatic wait_done(input int ch, input int max);
    for (int n = 0; n < max; n++) begin
      tick();
      if ((ch == 0 && done_0) || (ch == 1 && done_1)) return;
    end
    check($sformatf("done%0d_timeout", ch), (ch == 0) ? done_0 : done_1, 1'b1);
  endtask

  task automatic wait_idle(input int max);
    for (int n = 0; n < max; n++) begin
      tick();
      if (!busy) return;
    end
    check("busy_timeout", busy, 1'b0);
  endtask

  initial begin
    // Reset values
    tick(); tick();
    check("rst_req0", req_0, 3'b000);
    check("rst_req1", req_1, 3'b000);
    check("rst_done0", done_0, 1'b0);
    check("rst_done1", done_1, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready0", job_ready_0, 1'b1);
    check("rst_ready1", job_ready_1, 1'b1);
    reset = 1'b0;
    tick();

    // Single job, L=2
    offer(0, 4'd2);
    check("single_busy", busy, 1'b1);
    wait_idle(40);
    check("single_drained", q0.size(), 0);

    // L=0 on channel 1
    offer(1, 4'd0);
    wait_idle(40);
    check("l0_drained", q1.size(), 0);

    // Full FIFO with the arbiter held off: one job in the FSM plus DEPTH queued
    arb_en0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ff_ready_%0d", i), job_ready_0, 1'b1);
      offer(0, 4'(i % 4));
    end
    check("ff_full", job_ready_0, 1'b0);
    offer(0, 4'd7);
    check("ff_reject", q0.size(), 5);
    check("ff_req_wait", req_0, 3'b001);
    arb_en0 = 1'b1;
    wait_done(0, 40);
    check("ff_ready_at_done", job_ready_0, 1'b0);
    tick();
    check("ff_ready_drop", job_ready_0, 1'b0);
    tick();
    check("ff_ready_back", job_ready_0, 1'b1);
    wait_idle(200);
    check("ff_drained", q0.size(), 0);

    // Grant gap mid-XFER, L=3
    offer(0, 4'd3);
    for (int n = 0; n < 20 && g0 < 2; n++) tick();
    arb_en0 = 1'b0;
    tick();
    snap = g0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("gap_req_held", req_0, 3'b001);
      check("gap_cnt_frozen", g0, snap);
    end
    arb_en0 = 1'b1;
    wait_idle(40);
    check("gap_drained", q0.size(), 0);

    // Contention: ch0 granted first, ch1 waits in REQ
    arb_en1 = 1'b0;
    job_valid_0 = 1'b1; job_len_0 = 4'd2;
    job_valid_1 = 1'b1; job_len_1 = 4'd1;
    tick();
    job_valid_0 = 1'b0; job_valid_1 = 1'b0;
    wait_done(0, 40);
    check("cont_req1_hold", req_1, 3'b001);
    check("cont_busy_mid", busy, 1'b1);
    arb_en1 = 1'b1;
    wait_done(1, 40);
    check("cont_busy_ch1_drop", busy, 1'b1);
    wait_idle(40);
    check("cont_req0_idle", req_0, 3'b000);
    check("cont_req1_idle", req_1, 3'b000);
    check("cont_drained", q0.size() + q1.size(), 0);

    // Reset during XFER with two jobs queued
    offer(0, 4'd3);
    offer(0, 4'd2);
    offer(0, 4'd2);
    for (int n = 0; n < 20 && g0 < 2; n++) tick();
    check("mr_in_xfer", req_0, 3'b001);
    reset = 1'b1;
    #1;
    check("mr_req0", req_0, 3'b000);
    check("mr_done0", done_0, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_ready0", job_ready_0, 1'b1);
    q0.delete(); q1.delete();
    g0 = 0; g1 = 0;
    tick(); tick();
    check("mr_no_done", done_0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_post_req0", req_0, 3'b000);
      check("mr_post_busy", busy, 1'b0);
    end
    check("mr_post_ready0", job_ready_0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
